// File: rtl/rv_pipeline_pkg.sv
// Shared pipeline types and constants for the IF, IF/ID and ID stages.
package rv_pipeline_pkg;

    localparam int unsigned INST_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } if_state_e;

    // Redirect targets are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry {instruction, pc} holding register used while ID is stalled.
module if_hold_buffer
    import rv_pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] inst_in,
    input  logic [31:0]       pc_in,
    output logic [INST_W-1:0] inst_out,
    output logic [31:0]       pc_out
);

    logic [INST_W-1:0] inst_q, inst_d;
    logic [31:0]       pc_q, pc_d;

    always_comb begin
        inst_d = inst_q;
        pc_d   = pc_q;
        if (clear) begin
            inst_d = '0;
            pc_d   = '0;
        end else if (load) begin
            inst_d = inst_in;
            pc_d   = pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q <= '0;
            pc_q   <= '0;
        end else begin
            inst_q <= inst_d;
            pc_q   <= pc_d;
        end
    end

    assign inst_out = inst_q;
    assign pc_out   = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC ownership, single-outstanding memory reads,
// stall absorption via a hold buffer and branch/jump redirect handling.
module if_fetch_unit
    import rv_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              inst_mem_read_req,
    output logic [31:0]       inst_mem_addr,
    input  logic              inst_mem_ready,
    input  logic [INST_W-1:0] inst_mem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              IF_kick_up,
    output logic [INST_W-1:0] IF_inst,
    output logic [31:0]       IF_pc,
    output logic [31:0]       fetch_count
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic              buf_load, buf_clear;
    logic [INST_W-1:0] buf_inst;
    logic [31:0]       buf_pc;
    logic [31:0]       target_pc;

    assign target_pc = align_pc(redirect_pc);

    if_hold_buffer u_hold_buffer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (buf_load),
        .clear    (buf_clear),
        .inst_in  (inst_mem_rdata),
        .pc_in    (pc_q),
        .inst_out (buf_inst),
        .pc_out   (buf_pc)
    );

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        redir_pc_d        = redir_pc_q;
        inst_mem_read_req = 1'b0;
        IF_kick_up        = 1'b0;
        IF_inst           = '0;
        IF_pc             = pc_q;
        buf_load          = 1'b0;
        buf_clear         = 1'b0;

        case (state_q)
            BOOT: begin
                if (redirect_valid) pc_d = target_pc;
                state_d = FETCH;
            end
            FETCH: begin
                inst_mem_read_req = 1'b1;
                IF_inst           = inst_mem_rdata;
                if (redirect_valid) begin
                    // A read still in flight must be drained before refetching.
                    if (inst_mem_ready) begin
                        pc_d = target_pc;
                    end else begin
                        redir_pc_d = target_pc;
                        state_d    = DISCARD;
                    end
                end else if (inst_mem_ready && !stall) begin
                    IF_kick_up = 1'b1;
                    pc_d       = pc_q + PC_STEP;
                end else if (inst_mem_ready) begin
                    buf_load = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                IF_inst = buf_inst;
                IF_pc   = buf_pc;
                if (redirect_valid) begin
                    buf_clear = 1'b1;
                    pc_d      = target_pc;
                    state_d   = FETCH;
                end else if (!stall) begin
                    IF_kick_up = 1'b1;
                    pc_d       = buf_pc + PC_STEP;
                    state_d    = FETCH;
                end
            end
            DISCARD: begin
                inst_mem_read_req = 1'b1;
                if (inst_mem_ready) begin
                    pc_d    = redirect_valid ? target_pc : redir_pc_q;
                    state_d = FETCH;
                end else if (redirect_valid) begin
                    redir_pc_d = target_pc;
                end
            end
            default: state_d = BOOT;
        endcase

        fetch_count_d = fetch_count_q + {31'd0, IF_kick_up};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            redir_pc_q    <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_pc_q    <= redir_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign inst_mem_addr = pc_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit plus reset and PC-wrap sequences.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] rdata = '0;
    logic        stall = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] rpc = '0;

    logic        req, kick, req_w, kick_w;
    logic [31:0] addr, inst, ifpc, cnt, addr_w, inst_w, ifpc_w, cnt_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .reset(reset),
        .inst_mem_read_req(req), .inst_mem_addr(addr),
        .inst_mem_ready(ready), .inst_mem_rdata(rdata),
        .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
        .IF_kick_up(kick), .IF_inst(inst), .IF_pc(ifpc), .fetch_count(cnt)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset),
        .inst_mem_read_req(req_w), .inst_mem_addr(addr_w),
        .inst_mem_ready(ready), .inst_mem_rdata(rdata),
        .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
        .IF_kick_up(kick_w), .IF_inst(inst_w), .IF_pc(ifpc_w), .fetch_count(cnt_w)
    );

    typedef struct {
        logic        ready;
        logic [31:0] rdata;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_kick;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dat(input logic [31:0] pc);
        return 32'hA500_0000 ^ (pc * 32'd3);
    endfunction

    function automatic vec_t mk(input logic r, input logic [31:0] d, input logic s,
                                input logic v, input logic [31:0] p,
                                input logic eq, input logic [31:0] ea, input logic ek,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic [31:0] ec);
        vec_t t;
        t.ready = r; t.rdata = d; t.stall = s; t.rv = v; t.rpc = p;
        t.e_req = eq; t.e_addr = ea; t.e_kick = ek; t.e_inst = ei; t.e_pc = ep; t.e_cnt = ec;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ready = 1'b0; rdata = '0; stall = 1'b0; rv = 1'b0; rpc = '0;
    endtask

    initial begin
        logic [31:0] wrap_pc [3];
        wrap_pc[0] = 32'hFFFF_FFF8;
        wrap_pc[1] = 32'hFFFF_FFFC;
        wrap_pc[2] = 32'h0000_0000;

        // BOOT cycle, streaming from pc 0
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, dat(4*k), 0, 0, 0,   1, 4*k, 1, dat(4*k), 4*k, k));
        // stall at pc 32 for three cycles, then deliver from the buffer
        vecs.push_back(mk(1, dat(32), 1, 0, 0,        1, 32, 0, 0, 0, 8));
        vecs.push_back(mk(0, 0, 1, 0, 0,              0, 0, 0, 0, 0, 8));
        vecs.push_back(mk(0, 0, 1, 0, 0,              0, 0, 0, 0, 0, 8));
        vecs.push_back(mk(0, 0, 0, 0, 0,              0, 0, 1, dat(32), 32, 8));
        // redirect while waiting -> DISCARD, dropped response, refetch at 0x100
        vecs.push_back(mk(0, 0, 0, 0, 0,              1, 36, 0, 0, 0, 9));
        vecs.push_back(mk(0, 0, 0, 1, 32'h103,        1, 36, 0, 0, 0, 9));
        vecs.push_back(mk(0, 0, 0, 0, 0,              1, 36, 0, 0, 0, 9));
        vecs.push_back(mk(1, dat(36), 0, 0, 0,        1, 36, 0, 0, 0, 9));
        vecs.push_back(mk(1, dat(256), 0, 0, 0,       1, 256, 1, dat(256), 256, 9));
        // redirect in HOLD with stall released the same cycle
        vecs.push_back(mk(1, dat(260), 1, 0, 0,       1, 260, 0, 0, 0, 10));
        vecs.push_back(mk(0, 0, 0, 1, 32'h200,        0, 0, 0, 0, 0, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0,              1, 512, 0, 0, 0, 10));
        // redirect coincident with ready: response dropped
        vecs.push_back(mk(1, dat(512), 0, 1, 32'h300, 1, 512, 0, 0, 0, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0,              1, 768, 0, 0, 0, 10));
        // two redirects in DISCARD: latest wins
        vecs.push_back(mk(0, 0, 0, 1, 32'h400,        1, 768, 0, 0, 0, 10));
        vecs.push_back(mk(0, 0, 0, 1, 32'h502,        1, 768, 0, 0, 0, 10));
        vecs.push_back(mk(1, dat(768), 0, 0, 0,       1, 768, 0, 0, 0, 10));
        vecs.push_back(mk(1, dat(1280), 0, 0, 0,      1, 1280, 1, dat(1280), 1280, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0,              1, 1284, 0, 0, 0, 11));

        // reset values
        drive_idle();
        #12;
        check("rst_req", {31'd0, req}, 0);
        check("rst_addr", addr, 0);
        check("rst_kick", {31'd0, kick}, 0);
        check("rst_inst", inst, 0);
        check("rst_pc", ifpc, 0);
        check("rst_cnt", cnt, 0);
        check("rst_addr_w", addr_w, 32'hFFFF_FFF8);
        check("rst_pc_w", ifpc_w, 32'hFFFF_FFF8);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            ready = vecs[i].ready; rdata = vecs[i].rdata; stall = vecs[i].stall;
            rv = vecs[i].rv; rpc = vecs[i].rpc;
            #1;
            check($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, vecs[i].e_req});
            check($sformatf("v%0d_kick", i), {31'd0, kick}, {31'd0, vecs[i].e_kick});
            check($sformatf("v%0d_cnt", i), cnt, vecs[i].e_cnt);
            if (vecs[i].e_req) check($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
            if (vecs[i].e_kick) begin
                check($sformatf("v%0d_inst", i), inst, vecs[i].e_inst);
                check($sformatf("v%0d_pc", i), ifpc, vecs[i].e_pc);
            end
            if (i >= 1 && i <= 3) begin
                check($sformatf("wrap%0d_kick", i), {31'd0, kick_w}, 1);
                check($sformatf("wrap%0d_pc", i), ifpc_w, wrap_pc[i-1]);
            end
            $display("[TB] vec %0d req=%0b addr=%h kick=%0b pc=%h cnt=%0d",
                     i, req, addr, kick, ifpc, cnt);
        end

        // async reset mid-FETCH with ready low: outputs reset with no clock edge
        #1;
        reset = 1'b0;
        #1;
        check("arst_req", {31'd0, req}, 0);
        check("arst_addr", addr, 0);
        check("arst_kick", {31'd0, kick}, 0);
        check("arst_inst", inst, 0);
        check("arst_pc", ifpc, 0);
        check("arst_cnt", cnt, 0);
        $display("[TB] async reset req=%0b addr=%h cnt=%0d", req, addr, cnt);

        drive_idle();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("boot_req", {31'd0, req}, 0);
        @(negedge clk);
        #1;
        check("post_req", {31'd0, req}, 1);
        check("post_addr", addr, 0);
        check("post_cnt", cnt, 0);
        $display("[TB] post reset req=%0b addr=%h cnt=%0d", req, addr, cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
